// File: rtl/minirv_pkg.sv
// Shared types for the load/store unit: memory op encoding, LSU FSM states,
// lane/strobe geometry and small op-classification helpers.
package minirv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned NLANES = XLEN / LANE_W;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd3,
        LHU = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } lsu_state_t;

    function automatic logic is_store(input mem_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic misaligned(input mem_op_t op, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (op)
            LH, LHU, SH: bad = off[0];
            LW, SW:      bad = (off != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_wb_if.sv
// Request, memory and register-file writeback signals of the load/store unit.
// master = LSU side, slave = surrounding core/memory side.
interface lsu_wb_if #(
    parameter int unsigned NREGS = 16
);
    localparam int unsigned RW = $clog2(NREGS);

    logic                  req_valid;
    logic                  req_ready;
    minirv_pkg::mem_op_t   req_op;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic [RW-1:0]         req_rd;

    logic                  mem_req;
    logic                  mem_we;
    logic [31:0]           mem_addr;
    logic [3:0]            mem_wstrb;
    logic [31:0]           mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;

    logic                  rf_we;
    logic [RW-1:0]         rf_rd;
    logic [31:0]           rf_wdata;

    logic                  busy;
    logic                  err;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, req_rd,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output rf_we, rf_rd, rf_wdata, busy, err
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, req_rd,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  rf_we, rf_rd, rf_wdata, busy, err
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe/data replication for the incoming op
// and sign/zero-extended load extraction for the captured op.
module lsu_align
    import minirv_pkg::*;
(
    input  mem_op_t           st_op,
    input  logic [1:0]        st_off,
    input  logic [XLEN-1:0]   st_wdata,
    output logic [NLANES-1:0] wstrb,
    output logic [XLEN-1:0]   wdata,

    input  mem_op_t           ld_op,
    input  logic [1:0]        ld_off,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   ldata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        wstrb = '0;
        wdata = st_wdata;
        case (st_op)
            SB: begin
                wstrb = 4'b0001 << st_off;
                wdata = {4{st_wdata[7:0]}};
            end
            SH: begin
                wstrb = 4'b0011 << {st_off[1], 1'b0};
                wdata = {2{st_wdata[15:0]}};
            end
            SW:      wstrb = '1;
            default: wstrb = '0;
        endcase
    end

    always_comb begin
        ld_byte = 8'(rdata >> {ld_off, 3'b000});
        ld_half = 16'(rdata >> {ld_off[1], 4'b0000});
        case (ld_op)
            LB:      ldata = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            LBU:     ldata = {{(XLEN-8){1'b0}}, ld_byte};
            LH:      ldata = {{(XLEN-16){ld_half[15]}}, ld_half};
            LHU:     ldata = {{(XLEN-16){1'b0}}, ld_half};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_wb.sv
// Single-outstanding load/store unit with register-file writeback and WAIT timeout.
// Optional LSU_MISALIGN_TRAP_EN: reject misaligned half/word ops with an err pulse.
module lsu_wb
    import minirv_pkg::*;
#(
    parameter int unsigned NREGS          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
)(
    input  logic     clk,
    input  logic     rst,
    lsu_wb_if.master bus
);

    localparam int unsigned RW      = $clog2(NREGS);
    localparam logic [7:0]  TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state;
    mem_op_t          op_q;
    logic [1:0]       off_q;
    logic [RW-1:0]    rd_q;
    logic [7:0]       wait_cnt;

    logic             accept;
    logic             bad_align;
    logic [3:0]       st_wstrb;
    logic [31:0]      st_wdata;
    logic [31:0]      ld_data;

    lsu_align u_align (
        .st_op    (bus.req_op),
        .st_off   (bus.req_addr[1:0]),
        .st_wdata (bus.req_wdata),
        .wstrb    (st_wstrb),
        .wdata    (st_wdata),
        .ld_op    (op_q),
        .ld_off   (off_q),
        .rdata    (bus.mem_rdata),
        .ldata    (ld_data)
    );

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.busy      = (state != IDLE);
    assign accept        = bus.req_valid && bus.req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    assign bad_align = misaligned(bus.req_op, bus.req_addr[1:0]);
`else
    assign bad_align = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            op_q          <= LB;
            off_q         <= '0;
            rd_q          <= '0;
            wait_cnt      <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wstrb <= '0;
            bus.mem_wdata <= '0;
            bus.rf_we     <= 1'b0;
            bus.rf_rd     <= '0;
            bus.rf_wdata  <= '0;
            bus.err       <= 1'b0;
        end else begin
            bus.err   <= 1'b0;
            bus.rf_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bad_align) begin
                            bus.err <= 1'b1;
                        end else begin
                            op_q          <= bus.req_op;
                            off_q         <= bus.req_addr[1:0];
                            rd_q          <= bus.req_rd;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= is_store(bus.req_op);
                            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            bus.mem_wstrb <= st_wstrb;
                            bus.mem_wdata <= st_wdata;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) begin
                        bus.mem_req <= 1'b0;
                        if (is_store(op_q)) begin
                            state <= IDLE;
                        end else begin
                            wait_cnt <= '0;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // rvalid is tested first so it wins over a coincident timeout
                    if (bus.mem_rvalid) begin
                        bus.rf_wdata <= ld_data;
                        bus.rf_rd    <= rd_q;
                        bus.rf_we    <= (rd_q != '0);
                        state        <= WB;
                    end else if (wait_cnt == TO_LAST) begin
                        bus.err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WB: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_wb.md
LSU_WB -- requirements
Module: lsu_wb

Interface
REQ-001 SHALL have parameter NREGS, default 16: register-file depth; register index width is $clog2(NREGS).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..255: maximum number of WAIT cycles before abort.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: a memory op is offered.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept an op.
REQ-007 SHALL have port req_op, input, 3 bits, type mem_op_t: LB, LH, LW, LBU, LHU, SB, SH, SW.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, LSB-justified.
REQ-010 SHALL have port req_rd, input, $clog2(NREGS) bits: load destination register.
REQ-011 SHALL have port mem_req, output, 1 bit: memory request.
REQ-012 SHALL have port mem_we, output, 1 bit: memory write.
REQ-013 SHALL have port mem_addr, output, 32 bits: word-aligned memory address.
REQ-014 SHALL have port mem_wstrb, output, 4 bits: byte-lane write strobes.
REQ-015 SHALL have port mem_wdata, output, 32 bits: lane-replicated store data.
REQ-016 SHALL have port mem_gnt, input, 1 bit: memory accepts the request.
REQ-017 SHALL have port mem_rvalid, input, 1 bit: read data valid.
REQ-018 SHALL have port mem_rdata, input, 32 bits: read data.
REQ-019 SHALL have port rf_we, output, 1 bit: register-file write enable.
REQ-020 SHALL have port rf_rd, output, $clog2(NREGS) bits: register-file write index.
REQ-021 SHALL have port rf_wdata, output, 32 bits: register-file write data.
REQ-022 SHALL have port busy, output, 1 bit: FSM state is not IDLE.
REQ-023 SHALL have port err, output, 1 bit: one-cycle abort pulse.

Function
REQ-024 SHALL implement FSM states IDLE, REQ, WAIT, WB; req_ready = (state==IDLE) && !rst.
REQ-025 SHALL accept an op when req_valid && req_ready, registering op, addr, wdata and rd, then moving to REQ.
REQ-026 SHALL, in REQ: hold mem_req=1 with stable mem_we/addr/wstrb/wdata until mem_gnt=1; on grant a store goes to IDLE and a load goes to WAIT.
REQ-027 SHALL, in WAIT: on mem_rvalid capture the extracted data and go to WB; mem_rvalid in any other state is ignored.
REQ-028 SHALL, in WB: drive rf_we=1 for exactly one cycle with rf_rd/rf_wdata, then go to IDLE; if rd==0, rf_we=0 and rf_wdata is still updated.
REQ-029 SHALL have minimum latency, with mem_gnt in the first REQ cycle and mem_rvalid in the first WAIT cycle: load rf_we 3 cycles after accept; store back in IDLE 2 cycles after accept.
REQ-030 SHALL set mem_addr = {addr[31:2],2'b00}; with off = addr[1:0]: SB wstrb = 1<<off, wdata = {4{wdata[7:0]}}; SH wstrb = 4'b0011<<{off[1],1'b0}, wdata = {2{wdata[15:0]}}; SW wstrb = 4'hF; loads drive wstrb = 0.
REQ-031 SHALL extract load data as: LB/LBU = byte at lane off, sign-/zero-extended; LH/LHU = half at off[1], sign-/zero-extended; LW = full word.
REQ-032 SHALL run an 8-bit WAIT counter, cleared on WAIT entry; on reaching TIMEOUT_CYCLES without rvalid it pulses err for one cycle, returns to IDLE, and performs no writeback.
REQ-033 SHALL let mem_rvalid win when it coincides with the timeout cycle.

Reset
REQ-034 SHALL, while rst=1, force state IDLE, all outputs 0 (req_ready included), counter 0 and captured registers 0.
REQ-035 SHALL, on reset mid-operation, abandon the transaction: mem_req drops asynchronously and no rf_we is issued.

Configuration
REQ-036 SHALL, with LSU_MISALIGN_TRAP_EN defined, flag halfword ops with addr[0]=1 and word ops with addr[1:0]!=0: no mem_req, no rf_we, err=1 in the cycle after acceptance, FSM stays IDLE.
REQ-037 SHALL, without LSU_MISALIGN_TRAP_EN, ignore the misaligned low bits (treat as 0 for halves/words); err then comes only from timeout.

Structure
REQ-038 SHALL place mem_op_t, the FSM state enum and the lane/strobe width constants in package minirv_pkg.
REQ-039 SHALL implement strobe generation and load extraction in combinational sub-module lsu_align.

Verification
REQ-040 SHALL cover: LW addr 0x100, gnt immediate, rvalid next cycle, rdata 0xDEADBEEF, rd=5 -> rf_we 3 cycles after accept, rf_wdata 0xDEADBEEF.
REQ-041 SHALL cover: LB addr 0x103, rdata 0x80xxxxxx -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102, rdata 0xBEEF0000 -> 0x0000BEEF.
REQ-042 SHALL cover: SB addr 0x201, wdata 0x000000AB, gnt delayed 3 cycles -> mem_req held 4 cycles, wstrb 0010, mem_wdata 0xABABABAB, mem_addr 0x200.
REQ-043 SHALL cover: load with rvalid never asserted, TIMEOUT_CYCLES=4 -> err pulse after 4 WAIT cycles, no rf_we, req_ready=1 next cycle.
REQ-044 SHALL cover: LW addr 0x102 -> err with no mem_req when LSU_MISALIGN_TRAP_EN is defined; reads word 0x100 without it.
REQ-045 SHALL cover: rst asserted in WAIT -> mem_req, busy and rf_we 0 immediately; load to rd=0 -> rf_we stays 0.
